fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. Owns the program counter, drives it to the word-addressed instruction memory, accepts the combinational instruction word back, and registers instruction, PC and valid into the IF/ID pipeline register. Handles redirects from execute (taken BEQ), early JUMP redirect decoded in fetch, hazard-unit stalls and bubble insertion.

## Interface
Parameters:
- MEM_WORDS, 15, number of instruction words implemented; legal PCs are 0 .. 2*MEM_WORDS-2
- PC_STEP, 2, byte increment per sequential fetch

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect_valid  in  1  execute stage: taken branch, flush and load redirect_pc
- redirect_pc  in  16  branch target byte address
- pc_out  out  16  current fetch address, wired to instruction memory pc input
- instruction_in  in  16  instruction word returned combinationally for pc_out
- ifid_instruction  out  16  registered instruction to decode
- ifid_pc  out  16  registered address of ifid_instruction
- ifid_valid  out  1  ifid_instruction is a real fetched instruction, not a bubble
- fetch_fault  out  1  sticky: PC left legal range

## Operation
- Next-PC priority, highest first: reset > redirect_valid > stall > fetch-JUMP > sequential.
- reset: pc <= 0; ifid_instruction <= 16'h0000; ifid_pc <= 0; ifid_valid <= 0; fetch_fault <= 0.
- redirect_valid: pc <= {redirect_pc[15:1],1'b0}; IF/ID loaded with bubble (NOP 16'h0000, valid 0, ifid_pc unchanged). Applies even if stall is high.
- stall (no redirect): pc and all IF/ID outputs hold.
- fetch-JUMP: instruction_in[15:12] == 4'b1100 → pc <= {3'b000, instruction_in[11:0], 1'b0}; the JUMP itself enters IF/ID with valid 1 (decode treats it as NOP). No bubble needed.
- sequential: pc <= pc + PC_STEP; IF/ID <= {instruction_in, pc, 1}.
- Range check: if pc word index (pc[15:1]) ≥ MEM_WORDS, instruction_in is ignored; IF/ID gets NOP with valid 0; fetch_fault sets and stays set until reset; pc still follows the priority rules (a redirect can recover).
- Sequential wrap: pc = 2*MEM_WORDS-2 increments to 0 (no fault); pc arithmetic is 16-bit modulo otherwise.
- Misaligned redirect (bit 0 set): bit 0 forced to 0, no fault.

## Timing
- pc_out is a register output; instruction memory read is combinational in the same cycle.
- Fetch latency: instruction at address A appears on ifid_instruction one edge after pc_out = A.
- Sequential throughput: one instruction per cycle.
- Taken branch: redirect asserted in cycle N → cycle N+1 pc_out = target, IF/ID bubble; target instruction in IF/ID at N+2.
- JUMP: zero-bubble; target on pc_out the cycle after the JUMP is fetched.
- Reset mid-operation: overrides stall and redirect in the same edge; first valid IF/ID (address 0) one edge after reset drops.

## Structure
- Shared package: OP_JUMP = 4'b1100, OP_BEQ = 4'b1010, NOP = 16'h0000, opcode field [15:12], jump immediate field [11:0].
- One sub-module: next_pc_select (combinational priority mux and range check), top holds PC, IF/ID and fault registers.

## Test plan
- Reset held 2 cycles, release → pc_out 0,2,4,6 on consecutive cycles; ifid_pc 0,2,4 with valid 1; all outputs 0 during reset.
- stall high 3 cycles at pc_out=6 → pc_out and IF/ID frozen; release → 8 next cycle, no instruction lost or duplicated.
- redirect_valid with redirect_pc=16'h000D while stall=1 → next pc_out 0x000C, ifid_valid 0, ifid_instruction 0x0000.
- instruction_in 16'b1100_0000_0000_0100 at pc 0x10 → next pc_out 0x0008, IF/ID holds JUMP with ifid_pc 0x10, valid 1.
- Sequential run from 0x1C → next pc_out 0x0000, fetch_fault stays 0.
- redirect_pc 0x0020 → ifid_valid 0, fetch_fault 1 persistent; redirect to 0x0002 resumes valid fetch, fault stays 1 until reset.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared opcodes, field helpers and next-PC source encoding.
// Revision : 1.0
// ============================================================================
package fetch_stage_pkg;

    localparam logic [3:0]  c_OP_JUMP = 4'b1100;
    localparam logic [3:0]  c_OP_BEQ  = 4'b1010;
    localparam logic [15:0] c_NOP     = 16'h0000;

    typedef enum logic [1:0] {
        SRC_REDIRECT = 2'd0,
        SRC_STALL    = 2'd1,
        SRC_JUMP     = 2'd2,
        SRC_SEQ      = 2'd3
    } pc_src_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

    // The jump immediate is a word index; convert it to a byte address.
    function automatic logic [15:0] jump_target(input logic [15:0] instr);
        return {3'b000, instr[11:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Fetch-stage control, instruction-memory and IF/ID signal bundle.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out;
    logic [15:0] instruction_in;
    logic [15:0] ifid_instruction;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        fetch_fault;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  instruction_in,
        output pc_out,
        output ifid_instruction,
        output ifid_pc,
        output ifid_valid,
        output fetch_fault
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output instruction_in,
        input  pc_out,
        input  ifid_instruction,
        input  ifid_pc,
        input  ifid_valid,
        input  fetch_fault
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_next_pc_select.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_select
// Purpose  : Combinational next-PC priority mux and PC range check.
// Revision : 1.0
// ============================================================================
module next_pc_select
    import fetch_stage_pkg::*;
#(
    parameter int MEM_WORDS = 15,
    parameter int PC_STEP   = 2
) (
    input  wire logic [15:0] i_pc,
    input  wire logic        i_stall,
    input  wire logic        i_redirect_valid,
    input  wire logic [15:0] i_redirect_pc,
    input  wire logic [15:0] i_instruction,
    output      logic [15:0] o_next_pc,
    output      pc_src_t     o_src,
    output      logic        o_out_of_range
);

    localparam logic [14:0] c_mem_words = 15'(MEM_WORDS);
    localparam logic [15:0] c_last_pc   = 16'(2 * MEM_WORDS - 2);
    localparam logic [15:0] c_pc_step   = 16'(PC_STEP);

    logic w_is_jump;

    assign o_out_of_range = (i_pc[15:1] >= c_mem_words);
    // A fetched word outside memory is garbage, so it must not trigger a jump.
    assign w_is_jump      = !o_out_of_range && (opcode_of(i_instruction) == c_OP_JUMP);

    always_comb begin
        o_src     = SRC_SEQ;
        o_next_pc = i_pc + c_pc_step;
        if (i_redirect_valid) begin
            o_src     = SRC_REDIRECT;
            o_next_pc = i_redirect_pc & 16'hFFFE;
        end else if (i_stall) begin
            o_src     = SRC_STALL;
            o_next_pc = i_pc;
        end else if (w_is_jump) begin
            o_src     = SRC_JUMP;
            o_next_pc = jump_target(i_instruction);
        end else if (i_pc == c_last_pc) begin
            o_next_pc = 16'h0000;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch: PC register, IF/ID pipeline register, fault flag.
// Revision : 1.0
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int MEM_WORDS = 15,
    parameter int PC_STEP   = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_stage_if.master bus
);

    logic [15:0] r_pc;
    logic [15:0] r_ifid_instruction;
    logic [15:0] r_ifid_pc;
    logic        r_ifid_valid;
    logic        r_fetch_fault;

    logic [15:0] w_next_pc;
    pc_src_t     w_src;
    logic        w_out_of_range;

    next_pc_select #(
        .MEM_WORDS (MEM_WORDS),
        .PC_STEP   (PC_STEP)
    ) u_next_pc_select (
        .i_pc             (r_pc),
        .i_stall          (bus.stall),
        .i_redirect_valid (bus.redirect_valid),
        .i_redirect_pc    (bus.redirect_pc),
        .i_instruction    (bus.instruction_in),
        .o_next_pc        (w_next_pc),
        .o_src            (w_src),
        .o_out_of_range   (w_out_of_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc               <= 16'h0000;
            r_ifid_instruction <= c_NOP;
            r_ifid_pc          <= 16'h0000;
            r_ifid_valid       <= 1'b0;
            r_fetch_fault      <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_out_of_range) begin
                r_fetch_fault <= 1'b1;
            end
            case (w_src)
                SRC_REDIRECT: begin
                    // Flush: ifid_pc deliberately keeps its previous value.
                    r_ifid_instruction <= c_NOP;
                    r_ifid_valid       <= 1'b0;
                end
                SRC_STALL: begin
                end
                default: begin
                    r_ifid_pc <= r_pc;
                    if (w_out_of_range) begin
                        r_ifid_instruction <= c_NOP;
                        r_ifid_valid       <= 1'b0;
                    end else begin
                        r_ifid_instruction <= bus.instruction_in;
                        r_ifid_valid       <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.pc_out           = r_pc;
    assign bus.ifid_instruction = r_ifid_instruction;
    assign bus.ifid_pc          = r_ifid_pc;
    assign bus.ifid_valid       = r_ifid_valid;
    assign bus.fetch_fault      = r_fetch_fault;

endmodule
`default_nettype wire
